// File: rtl/alu_sched.sv
// Shares one combinational ALU between two valid/ready requesters. Round-robin
// tie-break, opcode-dependent operand hold time, single registered response.
module alu_sched #(
  parameter int WIDTH     = 16,
  parameter int OPW       = 5,
  parameter int INT_LAT   = 1,
  parameter int FLOAT_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int MAXL = (INT_LAT > FLOAT_LAT) ? INT_LAT : FLOAT_LAT;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic             rvld_q, rvld_d, rid_q, rid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             gnt0, gnt1;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Float class: invf, addf, mulf, f2i, i2f, only when the top opcode bit is clear.
  function automatic logic is_float(input logic [OPW-1:0] op);
    return !op[4] && (op[3:0] inside {4'd1, 4'd2, 4'd3, 4'd10, 4'd11});
  endfunction

  // On a tie the requester that did not win last time goes first.
  assign gnt0 = req0_valid && (!req1_valid || last_q);
  assign gnt1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;

  assign sel_op = gnt1 ? req1_op : req0_op;
  assign sel_a  = gnt1 ? req1_a  : req0_a;
  assign sel_b  = gnt1 ? req1_b  : req0_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    op_d    = op_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    rvld_d  = rvld_q;
    rid_d   = rid_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          op_d    = sel_op;
          in1_d   = sel_a;
          in2_d   = sel_b;
          rid_d   = gnt1;
          last_d  = gnt1;
          cnt_d   = is_float(sel_op) ? CW'(FLOAT_LAT - 1) : CW'(INT_LAT - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rdata_d = alu_result;
          rvld_d  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      op_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      rvld_q  <= 1'b0;
      rid_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      rvld_q  <= rvld_d;
      rid_q   <= rid_d;
      rdata_q <= rdata_d;
    end
  end

  assign alu_op    = op_q;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign rsp_valid = rvld_q;
  assign rsp_id    = rid_q;
  assign rsp_data  = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
